// File: rtl/scene_sequencer.sv
// Frame-rate scene controller: sequences background modes with black gaps,
// honours pause/skip, and drives the scroll counter and bouncing sprite origin.
module scene_sequencer #(
   parameter int SCENE_FRAMES = 120,
   parameter int GAP_FRAMES   = 8,
   parameter int NUM_SCENES   = 11,
   parameter int H_LIMIT      = 640,
   parameter int V_LIMIT      = 480,
   parameter int SPRITE_W     = 32,
   parameter int SPRITE_H     = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic       pause,
   input  logic       skip,
   output logic [7:0] background_state,
   output logic [5:0] solid_color,
   output logic       blank,
   output logic [9:0] moving_counter,
   output logic [9:0] sprite_x,
   output logic [9:0] sprite_y,
   output logic       frame_tick,
   output logic       scene_change
);

   localparam logic [0:0]  ST_SHOW    = 1'b0;
   localparam logic [0:0]  ST_GAP     = 1'b1;
   localparam logic [15:0] SHOW_LAST  = 16'(SCENE_FRAMES - 1);
   localparam logic [15:0] GAP_LAST   = 16'(GAP_FRAMES - 1);
   localparam logic [7:0]  LAST_SCENE = 8'(NUM_SCENES - 1);
   localparam logic [10:0] X_MAX      = 11'(H_LIMIT - SPRITE_W);
   localparam logic [10:0] Y_MAX      = 11'(V_LIMIT - SPRITE_H);

   logic        vsync_d_q;
   logic        tick_q;
   logic [0:0]  state_q,  state_d;
   logic [15:0] dwell_q,  dwell_d;
   logic        skip_q,   skip_d;
   logic [7:0]  scene_q,  scene_d;
   logic [5:0]  color_q,  color_d;
   logic [9:0]  moving_q, moving_d;
   logic [9:0]  x_q,      x_d;
   logic [9:0]  y_q,      y_d;
   logic        dir_x_q,  dir_x_d;
   logic        dir_y_q,  dir_y_d;
   logic        change_q, change_d;
   logic [10:0] bounce_x;
   logic [10:0] bounce_y;
   logic        skip_now;
   logic        move_en;

   // Returns {dir_neg_next, pos_next}; the limit value is emitted once and the
   // direction flips on that same step, so the turn-around reads 607, 608, 607.
   function automatic logic [10:0] bounce(input logic [9:0] pos,
                                          input logic dir_neg,
                                          input logic [10:0] lim);
      logic [10:0] up;
      logic [10:0] res;
      up = {1'b0, pos} + 11'd1;
      if (!dir_neg) begin
         if (up >= lim) res = {1'b1, lim[9:0]};
         else           res = {1'b0, up[9:0]};
      end else begin
         if (pos <= 10'd1) res = {1'b0, 10'd0};
         else              res = {1'b1, pos - 10'd1};
      end
      return res;
   endfunction

   assign bounce_x = bounce(x_q, dir_x_q, X_MAX);
   assign bounce_y = bounce(y_q, dir_y_q, Y_MAX);
   assign skip_now = skip_q | skip;
   assign move_en  = tick_q & ~pause & (state_q == ST_SHOW);

   always_comb begin
      state_d  = state_q;
      dwell_d  = dwell_q;
      skip_d   = skip_now;
      scene_d  = scene_q;
      color_d  = color_q;
      moving_d = moving_q;
      x_d      = x_q;
      y_d      = y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      change_d = 1'b0;

      if (move_en) begin
         moving_d = moving_q + 10'd1;
         x_d      = bounce_x[9:0];
         dir_x_d  = bounce_x[10];
         y_d      = bounce_y[9:0];
         dir_y_d  = bounce_y[10];
      end

      // Any pending skip forces a transition on this tick, so the latch always empties here.
      if (tick_q) begin
         skip_d = 1'b0;
         case (state_q)
            ST_SHOW: begin
               if (skip_now || (!pause && dwell_q == SHOW_LAST)) begin
                  state_d = ST_GAP;
                  dwell_d = 16'd0;
               end else if (!pause) begin
                  dwell_d = dwell_q + 16'd1;
               end
            end
            default: begin
               if (skip_now || dwell_q == GAP_LAST) begin
                  state_d  = ST_SHOW;
                  dwell_d  = 16'd0;
                  change_d = 1'b1;
                  if (scene_q == LAST_SCENE) begin
                     scene_d = 8'd0;
                     color_d = {color_q[3:0], color_q[5:4]};
                  end else begin
                     scene_d = scene_q + 8'd1;
                  end
               end else begin
                  dwell_d = dwell_q + 16'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_d_q <= 1'b0;
         tick_q    <= 1'b0;
         state_q   <= ST_SHOW;
         dwell_q   <= 16'd0;
         skip_q    <= 1'b0;
         scene_q   <= 8'd0;
         color_q   <= 6'b110000;
         moving_q  <= 10'd0;
         x_q       <= 10'd0;
         y_q       <= 10'd0;
         dir_x_q   <= 1'b0;
         dir_y_q   <= 1'b0;
         change_q  <= 1'b0;
      end else begin
         vsync_d_q <= vsync;
         tick_q    <= vsync & ~vsync_d_q;
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         skip_q    <= skip_d;
         scene_q   <= scene_d;
         color_q   <= color_d;
         moving_q  <= moving_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_x_q   <= dir_x_d;
         dir_y_q   <= dir_y_d;
         change_q  <= change_d;
      end
   end

   assign background_state = scene_q;
   assign solid_color      = color_q;
   assign blank            = (state_q == ST_GAP);
   assign moving_counter   = moving_q;
   assign sprite_x         = x_q;
   assign sprite_y         = y_q;
   assign frame_tick       = tick_q;
   assign scene_change     = change_q;

endmodule
